// File: rtl/native2axil.sv
// native2axil: AXI4-Lite master driven by a native pulse-request interface.
// Native side issues single-beat register reads/writes; one transaction is
// in flight at a time.
//
// Ports
//   AXI_ACLK, AXI_ARESET        clock, synchronous active-high reset
//   WEN/WADDR/WDATA             write request (sampled in IDLE only)
//   WACK/WERR                   write done pulse, |BRESP of last write
//   REN/RADDR                   read request (sampled in IDLE only)
//   RDATA/RVALID/RERR           read data (held), done pulse, |RRESP of last read
//   BUSY                        high whenever a transaction is in progress
//   DROP                        pulse: a request was discarded
//   AXI_AW*/W*/B*/AR*/R*        AXI4-Lite master channels
module native2axil #(
    parameter int       DATA_WIDTH = 32,
    parameter int       ADDR_WIDTH = 32,
    parameter bit [2:0] PROT       = 3'b000
) (
    input  logic                      AXI_ACLK,
    input  logic                      AXI_ARESET,

    input  logic                      WEN,
    input  logic [ADDR_WIDTH-1:0]     WADDR,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    output logic                      WACK,
    output logic                      WERR,

    input  logic                      REN,
    input  logic [ADDR_WIDTH-1:0]     RADDR,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic                      RVALID,
    output logic                      RERR,

    output logic                      BUSY,
    output logic                      DROP,

    output logic [ADDR_WIDTH-1:0]     AXI_AWADDR,
    output logic [2:0]                AXI_AWPROT,
    output logic                      AXI_AWVALID,
    input  logic                      AXI_AWREADY,

    output logic [DATA_WIDTH-1:0]     AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   AXI_WSTRB,
    output logic                      AXI_WVALID,
    input  logic                      AXI_WREADY,

    input  logic [1:0]                AXI_BRESP,
    input  logic                      AXI_BVALID,
    output logic                      AXI_BREADY,

    output logic [ADDR_WIDTH-1:0]     AXI_ARADDR,
    output logic [2:0]                AXI_ARPROT,
    output logic                      AXI_ARVALID,
    input  logic                      AXI_ARREADY,

    input  logic [DATA_WIDTH-1:0]     AXI_RDATA,
    input  logic [1:0]                AXI_RRESP,
    input  logic                      AXI_RVALID,
    output logic                      AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRITE_RESP,
        READ_ADDR,
        READ_DATA
    } state_t;

    state_t state;

    assign AXI_WSTRB  = '1;
    assign AXI_AWPROT = PROT;
    assign AXI_ARPROT = PROT;
    assign BUSY       = (state != IDLE);

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state       <= IDLE;
            WACK        <= 1'b0;
            WERR        <= 1'b0;
            RDATA       <= '0;
            RVALID      <= 1'b0;
            RERR        <= 1'b0;
            DROP        <= 1'b0;
            AXI_AWADDR  <= '0;
            AXI_AWVALID <= 1'b0;
            AXI_WDATA   <= '0;
            AXI_WVALID  <= 1'b0;
            AXI_BREADY  <= 1'b0;
            AXI_ARADDR  <= '0;
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b0;
        end else begin
            WACK   <= 1'b0;
            RVALID <= 1'b0;
            DROP   <= 1'b0;

            case (state)
                IDLE: begin
                    if (WEN) begin
                        AXI_AWADDR  <= WADDR;
                        AXI_WDATA   <= WDATA;
                        AXI_AWVALID <= 1'b1;
                        AXI_WVALID  <= 1'b1;
                        // A simultaneous read loses to the write.
                        DROP        <= REN;
                        state       <= WRITE;
                    end else if (REN) begin
                        AXI_ARADDR  <= RADDR;
                        AXI_ARVALID <= 1'b1;
                        state       <= READ_ADDR;
                    end
                end

                WRITE: begin
                    DROP <= WEN | REN;
                    if (AXI_AWVALID && AXI_AWREADY) AXI_AWVALID <= 1'b0;
                    if (AXI_WVALID  && AXI_WREADY)  AXI_WVALID  <= 1'b0;
                    // A cleared VALID means that channel already completed;
                    // move on once neither channel is still outstanding.
                    if ((!AXI_AWVALID || AXI_AWREADY) &&
                        (!AXI_WVALID  || AXI_WREADY)) begin
                        AXI_BREADY <= 1'b1;
                        state      <= WRITE_RESP;
                    end
                end

                WRITE_RESP: begin
                    DROP <= WEN | REN;
                    if (AXI_BVALID) begin
                        AXI_BREADY <= 1'b0;
                        WACK       <= 1'b1;
                        WERR       <= |AXI_BRESP;
                        state      <= IDLE;
                    end
                end

                READ_ADDR: begin
                    DROP <= WEN | REN;
                    if (AXI_ARREADY) begin
                        AXI_ARVALID <= 1'b0;
                        AXI_RREADY  <= 1'b1;
                        state       <= READ_DATA;
                    end
                end

                READ_DATA: begin
                    DROP <= WEN | REN;
                    if (AXI_RVALID) begin
                        AXI_RREADY <= 1'b0;
                        RDATA      <= AXI_RDATA;
                        RVALID     <= 1'b1;
                        RERR       <= |AXI_RRESP;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_native2axil.sv
// tb_native2axil: directed self-checking bench for native2axil.
// A small AXI4-Lite slave with programmable ready/response delays runs on
// the falling edge; the main sequence drives native requests on the falling
// edge and checks DUT outputs there, half a cycle after the active edge.
module tb_native2axil;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wen, ren;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic          wack, werr, rvalid, rerr, busy, drop;
    logic [DW-1:0] rdata;

    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready;
    logic [DW-1:0] axi_wdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready;
    logic [DW-1:0] axi_rdata;
    logic          axi_rvalid, rready;

    native2axil #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROT(3'b000)) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESET (rst),
        .WEN        (wen),
        .WADDR      (waddr),
        .WDATA      (wdata),
        .WACK       (wack),
        .WERR       (werr),
        .REN        (ren),
        .RADDR      (raddr),
        .RDATA      (rdata),
        .RVALID     (rvalid),
        .RERR       (rerr),
        .BUSY       (busy),
        .DROP       (drop),
        .AXI_AWADDR (awaddr),
        .AXI_AWPROT (awprot),
        .AXI_AWVALID(awvalid),
        .AXI_AWREADY(awready),
        .AXI_WDATA  (axi_wdata),
        .AXI_WSTRB  (wstrb),
        .AXI_WVALID (wvalid),
        .AXI_WREADY (wready),
        .AXI_BRESP  (bresp),
        .AXI_BVALID (bvalid),
        .AXI_BREADY (bready),
        .AXI_ARADDR (araddr),
        .AXI_ARPROT (arprot),
        .AXI_ARVALID(arvalid),
        .AXI_ARREADY(arready),
        .AXI_RDATA  (axi_rdata),
        .AXI_RRESP  (rresp),
        .AXI_RVALID (axi_rvalid),
        .AXI_RREADY (rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and observation.
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]    bresp_v = 2'b00, rresp_v = 2'b00;
    logic [DW-1:0] rdata_v = '0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [AW-1:0] aw_addr_cap = '0, ar_addr_cap = '0;
    logic [DW-1:0] w_data_cap = '0;
    logic [DW/8-1:0] wstrb_cap = '0;

    // A handshake is counted on the falling edge where READY is raised
    // against a high VALID; it completes on the following rising edge.
    initial begin
        int aw_wait, w_wait, b_wait, ar_wait, r_wait;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (awvalid) begin
                if (aw_wait >= aw_delay) begin
                    awready = 1'b1; aw_hs++; aw_addr_cap = awaddr;
                end else begin
                    awready = 1'b0; aw_wait++;
                end
            end else begin
                awready = 1'b0; aw_wait = 0;
            end

            if (wvalid) begin
                if (w_wait >= w_delay) begin
                    wready = 1'b1; w_hs++; w_data_cap = axi_wdata; wstrb_cap = wstrb;
                end else begin
                    wready = 1'b0; w_wait++;
                end
            end else begin
                wready = 1'b0; w_wait = 0;
            end

            if (bready) begin
                if (b_wait >= b_delay) begin
                    bvalid = 1'b1; bresp = bresp_v; b_hs++;
                end else begin
                    bvalid = 1'b0; bresp = 2'b00; b_wait++;
                end
            end else begin
                bvalid = 1'b0; bresp = 2'b00; b_wait = 0;
            end

            if (arvalid) begin
                if (ar_wait >= ar_delay) begin
                    arready = 1'b1; ar_hs++; ar_addr_cap = araddr;
                end else begin
                    arready = 1'b0; ar_wait++;
                end
            end else begin
                arready = 1'b0; ar_wait = 0;
            end

            if (rready) begin
                if (r_wait >= r_delay) begin
                    axi_rvalid = 1'b1; axi_rdata = rdata_v; rresp = rresp_v; r_hs++;
                end else begin
                    axi_rvalid = 1'b0; axi_rdata = '0; rresp = 2'b00; r_wait++;
                end
            end else begin
                axi_rvalid = 1'b0; axi_rdata = '0; rresp = 2'b00; r_wait = 0;
            end
        end
    end

    // Bounded waits; n is the number of falling edges stepped, -1 on timeout.
    task automatic wait_wack(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (wack) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_rvalid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rvalid) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int s_aw, s_w, s_b, s_ar, s_r;

    task automatic snap();
        s_aw = aw_hs; s_w = w_hs; s_b = b_hs; s_ar = ar_hs; s_r = r_hs;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid",  wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready",  bready, 0);
        check("rst_rready",  rready, 0);
        check("rst_busy",    busy, 0);
        check("rst_flags",   {wack, werr, rvalid, rerr, drop}, 0);
        check("rst_rdata",   rdata, 0);
        check("rst_awaddr",  awaddr, 0);
        check("rst_wdata",   axi_wdata, 0);
        check("rst_wstrb",   wstrb, 4'hF);
        check("rst_prot",    {awprot, arprot}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: write with always-ready slave.
        snap();
        wen = 1'b1; waddr = 32'h10; wdata = 32'hDEADBEEF;
        @(negedge clk);
        wen = 1'b0;
        check("t1_awvalid", awvalid, 1);
        check("t1_wvalid",  wvalid, 1);
        check("t1_awaddr",  awaddr, 32'h10);
        check("t1_wdata",   axi_wdata, 32'hDEADBEEF);
        check("t1_busy",    busy, 1);
        check("t1_bready0", bready, 0);
        @(negedge clk);
        check("t1_bready",  bready, 1);
        check("t1_awclr",   awvalid, 0);
        check("t1_wack0",   wack, 0);
        @(negedge clk);
        check("t1_wack",    wack, 1);
        check("t1_werr",    werr, 0);
        check("t1_busy0",   busy, 0);
        @(negedge clk);
        check("t1_wack_pulse", wack, 0);
        check("t1_aw_hs", aw_hs - s_aw, 1);
        check("t1_w_hs",  w_hs - s_w, 1);
        check("t1_b_hs",  b_hs - s_b, 1);
        check("t1_aw_cap", aw_addr_cap, 32'h10);
        check("t1_w_cap",  w_data_cap, 32'hDEADBEEF);
        check("t1_strb_cap", wstrb_cap, 4'hF);

        // 2: AWREADY delayed 4 cycles, WREADY immediate, error response.
        aw_delay = 4; bresp_v = 2'b11;
        snap();
        wen = 1'b1; waddr = 32'h44; wdata = 32'h12345678;
        @(negedge clk);
        wen = 1'b0;
        check("t2_wvalid",  wvalid, 1);
        check("t2_awvalid", awvalid, 1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check("t2_wvalid_clr",  wvalid, 0);
            check("t2_awvalid_hold", awvalid, 1);
            check("t2_awaddr_stable", awaddr, 32'h44);
            check("t2_bready0", bready, 0);
        end
        wait_wack(n);
        check("t2_wack_lat", n, 2);
        check("t2_werr", werr, 1);
        check("t2_aw_hs", aw_hs - s_aw, 1);
        check("t2_w_hs",  w_hs - s_w, 1);
        check("t2_b_hs",  b_hs - s_b, 1);
        aw_delay = 0; bresp_v = 2'b00;
        @(negedge clk);

        // 3: read with 3-cycle RVALID wait and SLVERR.
        r_delay = 3; rresp_v = 2'b10; rdata_v = 32'hCAFEF00D;
        snap();
        ren = 1'b1; raddr = 32'h20;
        @(negedge clk);
        ren = 1'b0;
        check("t3_arvalid", arvalid, 1);
        check("t3_araddr",  araddr, 32'h20);
        check("t3_busy",    busy, 1);
        wait_rvalid(n);
        check("t3_rvalid_lat", n, 5);
        check("t3_rdata", rdata, 32'hCAFEF00D);
        check("t3_rerr",  rerr, 1);
        check("t3_busy0", busy, 0);
        @(negedge clk);
        check("t3_rvalid_pulse", rvalid, 0);
        check("t3_rdata_hold", rdata, 32'hCAFEF00D);
        check("t3_ar_hs", ar_hs - s_ar, 1);
        check("t3_r_hs",  r_hs - s_r, 1);
        check("t3_ar_cap", ar_addr_cap, 32'h20);
        r_delay = 0; rresp_v = 2'b00;

        // 4: simultaneous WEN/REN, then REN while busy.
        snap();
        wen = 1'b1; ren = 1'b1; waddr = 32'h30; wdata = 32'h0000A5A5; raddr = 32'h34;
        @(negedge clk);
        wen = 1'b0; ren = 1'b1; raddr = 32'h38;
        check("t4_drop_both", drop, 1);
        check("t4_awvalid", awvalid, 1);
        check("t4_arvalid", arvalid, 0);
        @(negedge clk);
        ren = 1'b0;
        check("t4_drop_busy", drop, 1);
        check("t4_arvalid_busy", arvalid, 0);
        wait_wack(n);
        check("t4_wack_lat", n, 1);
        check("t4_drop_clr", drop, 0);
        check("t4_ar_hs", ar_hs - s_ar, 0);
        check("t4_aw_hs", aw_hs - s_aw, 1);
        check("t4_aw_cap", aw_addr_cap, 32'h30);
        @(negedge clk);
        check("t4_arvalid_after", arvalid, 0);

        // 5: reset while waiting in WRITE_RESP, then a read.
        b_delay = 5;
        snap();
        wen = 1'b1; waddr = 32'h50; wdata = 32'h1;
        @(negedge clk);
        wen = 1'b0;
        @(negedge clk);
        check("t5_bready", bready, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_valids", {awvalid, wvalid, arvalid}, 0);
        check("t5_readies", {bready, rready}, 0);
        check("t5_busy", busy, 0);
        check("t5_wack", wack, 0);
        check("t5_rdata", rdata, 0);
        check("t5_b_hs", b_hs - s_b, 0);
        rst = 1'b0; b_delay = 0; rdata_v = 32'h0BADF00D; rresp_v = 2'b00;
        ren = 1'b1; raddr = 32'h24;
        @(negedge clk);
        ren = 1'b0;
        check("t5_arvalid", arvalid, 1);
        check("t5_araddr",  araddr, 32'h24);
        wait_rvalid(n);
        check("t5_rvalid_lat", n, 2);
        check("t5_rdata_rd", rdata, 32'h0BADF00D);
        check("t5_rerr", rerr, 0);
        @(negedge clk);

        // 6: back-to-back write accepted in the WACK cycle.
        wen = 1'b1; waddr = 32'h60; wdata = 32'h11111111;
        wait_wack(n);
        wen = 1'b0;
        check("t6_wack_lat1", n, 3);
        wen = 1'b1; waddr = 32'h64; wdata = 32'h22222222;
        @(negedge clk);
        wen = 1'b0;
        check("t6_drop", drop, 0);
        check("t6_awvalid", awvalid, 1);
        check("t6_awaddr", awaddr, 32'h64);
        check("t6_wdata", axi_wdata, 32'h22222222);
        wait_wack(n);
        check("t6_wack_lat2", n, 2);
        check("t6_werr", werr, 0);
        check("t6_aw_cap", aw_addr_cap, 32'h64);
        check("t6_w_cap", w_data_cap, 32'h22222222);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
